// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter slice.
// Contents:
//   arb_state_e  - two-state arbiter FSM encoding (IDLE, GRANT)
//   idx_width()  - index width helper: $clog2(n) with a floor of 1, so
//                  parameter corners (n = 1 or 2) never yield a zero-width bus
package arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic int idx_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker, purely combinational.
// Finds the first set bit of req scanning upward from index start, wrapping
// from N-1 back to 0.
// Ports:
//   req        in   N   request vector
//   start      in   IW  index with highest priority
//   pick_idx   out  IW  index of the selected requester (0 when none)
//   pick_valid out  1   at least one request bit is set
module rr_pick
    import arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [IW-1:0] pick_idx,
    output logic          pick_valid
);

    // Doubling the vector and shifting by start puts the scan order in bits
    // [N-1:0]: bit i of rot_s is requester (start + i) mod N.
    logic [2*N-1:0] rot_s;
    logic [IW:0]    sum_s;

    assign rot_s = {req, req} >> start;

    // First-set scan of the rotated vector, mapped back to an absolute index.
    always_comb begin
        pick_idx   = {IW{1'b0}};
        pick_valid = 1'b0;
        sum_s      = {(IW+1){1'b0}};
        for (int i = 0; i < N; i++) begin
            if (!pick_valid && rot_s[i]) begin
                pick_valid = 1'b1;
                sum_s      = {1'b0, start} + (IW+1)'(i);
                if (sum_s >= (IW+1)'(N)) begin
                    pick_idx = IW'(sum_s - (IW+1)'(N));
                end else begin
                    pick_idx = sum_s[IW-1:0];
                end
            end else begin
                pick_valid = pick_valid;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_hold.sv
// Round-robin arbiter with registered one-hot grant, grant hold and a burst
// limit that forces rotation when other requesters are waiting.
// Ports:
//   clk      in   1          rising-edge clock
//   rst      in   1          asynchronous active-high reset
//   req      in   N          level-sensitive request vector
//   gnt      out  N          registered grant, one-hot or zero
//   gnt_idx  out  clog2(N)   binary index of the owner, 0 when idle
//   valid    out  1          high exactly when gnt is non-zero
// MAX_HOLD = 0 disables the burst limit (owner keeps the grant indefinitely).
module rr_arbiter_hold
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 valid
);

    localparam int              IW        = idx_width(N);
    localparam int              HW        = idx_width(MAX_HOLD + 1);
    localparam logic [HW-1:0]   HOLD_MAX  = HW'(MAX_HOLD);
    localparam logic [IW-1:0]   LAST_IDX  = IW'(N - 1);
    localparam bit              UNLIMITED = (MAX_HOLD == 32'sd0);

    arb_state_e     state_r;
    logic [IW-1:0]  last_r;
    logic [HW-1:0]  hold_cnt_r;

    logic [IW-1:0]  start_s;
    logic [IW-1:0]  pick_idx_s;
    logic           pick_valid_s;
    logic           owner_req_s;
    logic           others_s;
    logic           at_limit_s;
    logic           take_s;
    logic           bump_s;

    // Scan starts just after the last owner. While a grant is held last_r is
    // the owner, so a forced rotation reaches every other requester before
    // wrapping back to the owner.
    always_comb begin
        if (last_r == LAST_IDX) begin
            start_s = {IW{1'b0}};
        end else begin
            start_s = last_r + 1'b1;
        end
    end

    rr_pick #(
        .N (N)
    ) u_pick (
        .req        (req),
        .start      (start_s),
        .pick_idx   (pick_idx_s),
        .pick_valid (pick_valid_s)
    );

    // gnt is one-hot on the owner while in GRANT, so masking with it splits
    // req into "owner still requesting" and "somebody else is waiting".
    assign owner_req_s = |(req & gnt);
    assign others_s    = |(req & ~gnt);
    assign at_limit_s  = !UNLIMITED && (hold_cnt_r == HOLD_MAX);

    // Transition decision: take a new owner from the picker, extend the
    // current grant, or (neither) fall back to idle.
    always_comb begin
        take_s = 1'b0;
        bump_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    take_s = 1'b1;
                end else begin
                    take_s = 1'b0;
                end
            end
            GRANT: begin
                if (owner_req_s) begin
                    if (!at_limit_s) begin
                        bump_s = 1'b1;
                    end else if (others_s) begin
                        take_s = 1'b1;
                    end else begin
                        bump_s = 1'b1;
                    end
                end else if (pick_valid_s) begin
                    take_s = 1'b1;
                end else begin
                    take_s = 1'b0;
                end
            end
            default: begin
                take_s = 1'b0;
            end
        endcase
    end

    // Arbiter FSM with registered grant outputs and hold counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            last_r     <= LAST_IDX;
            hold_cnt_r <= {HW{1'b0}};
            gnt        <= {N{1'b0}};
            gnt_idx    <= {IW{1'b0}};
            valid      <= 1'b0;
        end else if (take_s) begin
            state_r    <= GRANT;
            last_r     <= pick_idx_s;
            hold_cnt_r <= HW'(1);
            gnt        <= {{(N-1){1'b0}}, 1'b1} << pick_idx_s;
            gnt_idx    <= pick_idx_s;
            valid      <= 1'b1;
        end else if (bump_s) begin
            // Saturation is implicit: bump_s without take_s at the limit only
            // happens when the owner is alone, and then the count is held.
            if (UNLIMITED || at_limit_s) begin
                hold_cnt_r <= hold_cnt_r;
            end else begin
                hold_cnt_r <= hold_cnt_r + 1'b1;
            end
        end else begin
            state_r    <= IDLE;
            hold_cnt_r <= {HW{1'b0}};
            gnt        <= {N{1'b0}};
            gnt_idx    <= {IW{1'b0}};
            valid      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_hold.sv
// Bench for rr_arbiter_hold: instance A (N=4, MAX_HOLD=4) and instance B
// (N=4, MAX_HOLD=0). Directed table vectors, hand-written reset and
// unlimited-hold sequences, then randomized traffic against a reference model.
module tb_rr_arbiter_hold;

    logic       clk;
    logic       rst;
    logic [3:0] req_a, gnt_a, req_b, gnt_b;
    logic [1:0] idx_a, idx_b;
    logic       val_a, val_b;

    int n_checks;
    int n_errors;

    rr_arbiter_hold #(.N(4), .MAX_HOLD(4)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a), .gnt_idx(idx_a), .valid(val_a)
    );

    rr_arbiter_hold #(.N(4), .MAX_HOLD(0)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .gnt_idx(idx_b), .valid(val_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       valid;
    } vec_t;

    vec_t vecs[$];

    // Reference model: owner (-1 = none), cycles held, last owner.
    int m_owner[2];
    int m_cnt[2];
    int m_last[2];
    int m_mh[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pick_from(input logic [3:0] r, input int from);
        for (int i = 1; i <= 4; i++) begin
            if (r[(from + i) % 4]) return (from + i) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_cnt[k]   = 0;
            m_last[k]  = 3;
        end
    endtask

    task automatic model_step(input int k, input logic [3:0] r);
        int o;
        o = m_owner[k];
        if (o < 0) begin
            if (r != 4'b0000) begin
                m_owner[k] = pick_from(r, m_last[k]);
                m_cnt[k]   = 1;
                m_last[k]  = m_owner[k];
            end
        end else if (r[o]) begin
            if (m_mh[k] == 0 || m_cnt[k] < m_mh[k]) begin
                if (m_mh[k] != 0) m_cnt[k]++;
            end else if ((r & ~(4'b0001 << o)) != 4'b0000) begin
                m_owner[k] = pick_from(r, o);
                m_cnt[k]   = 1;
                m_last[k]  = m_owner[k];
            end
        end else if (r != 4'b0000) begin
            m_owner[k] = pick_from(r, m_last[k]);
            m_cnt[k]   = 1;
            m_last[k]  = m_owner[k];
        end else begin
            m_owner[k] = -1;
            m_cnt[k]   = 0;
        end
    endtask

    task automatic check_inst(input int k, input string tag);
        logic [3:0] eg;
        logic [1:0] ei;
        eg = (m_owner[k] < 0) ? 4'b0000 : (4'b0001 << m_owner[k]);
        ei = (m_owner[k] < 0) ? 2'd0 : 2'(m_owner[k]);
        if (k == 0) begin
            check({tag, " gnt_a"}, 32'(gnt_a), 32'(eg));
            check({tag, " idx_a"}, 32'(idx_a), 32'(ei));
            check({tag, " valid_a"}, 32'(val_a), 32'(eg != 4'b0000));
        end else begin
            check({tag, " gnt_b"}, 32'(gnt_b), 32'(eg));
            check({tag, " idx_b"}, 32'(idx_b), 32'(ei));
            check({tag, " valid_b"}, 32'(val_b), 32'(eg != 4'b0000));
        end
    endtask

    // Drive at a falling edge, let one rising edge sample, return at the next
    // falling edge where outputs are stable.
    task automatic step(input logic [3:0] ra, input logic [3:0] rb);
        req_a = ra;
        req_b = rb;
        @(posedge clk);
        model_step(0, ra);
        model_step(1, rb);
        @(negedge clk);
    endtask

    task automatic add_vec(input logic [3:0] r, input logic [3:0] g, input logic [1:0] ix,
                           input logic v, input int n);
        vec_t e;
        e.req = r; e.gnt = g; e.idx = ix; e.valid = v;
        for (int i = 0; i < n; i++) vecs.push_back(e);
    endtask

    initial begin
        logic [3:0] ra, rb;
        n_checks = 0;
        n_errors = 0;
        m_mh[0] = 4;
        m_mh[1] = 0;
        model_reset();

        // Directed sequence for instance A (MAX_HOLD=4).
        add_vec(4'b1111, 4'b0001, 2'd0, 1'b1, 4);
        add_vec(4'b1111, 4'b0010, 2'd1, 1'b1, 4);
        add_vec(4'b1111, 4'b0100, 2'd2, 1'b1, 4);
        add_vec(4'b1111, 4'b1000, 2'd3, 1'b1, 4);
        add_vec(4'b1111, 4'b0001, 2'd0, 1'b1, 1);
        add_vec(4'b0100, 4'b0100, 2'd2, 1'b1, 20);
        add_vec(4'b0010, 4'b0010, 2'd1, 1'b1, 1);
        add_vec(4'b1010, 4'b0010, 2'd1, 1'b1, 1);
        add_vec(4'b1000, 4'b1000, 2'd3, 1'b1, 1);
        add_vec(4'b0000, 4'b0000, 2'd0, 1'b0, 1);
        add_vec(4'b0011, 4'b0001, 2'd0, 1'b1, 1);
        add_vec(4'b0100, 4'b0100, 2'd2, 1'b1, 1);

        rst   = 1'b1;
        req_a = 4'b0000;
        req_b = 4'b0000;
        repeat (2) @(negedge clk);
        check("reset gnt_a", 32'(gnt_a), 32'h0);
        check("reset idx_a", 32'(idx_a), 32'h0);
        check("reset valid_a", 32'(val_a), 32'h0);
        check("reset gnt_b", 32'(gnt_b), 32'h0);
        check("reset valid_b", 32'(val_b), 32'h0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].req, 4'b0000);
            check($sformatf("vec%0d gnt", i), 32'(gnt_a), 32'(vecs[i].gnt));
            check($sformatf("vec%0d idx", i), 32'(idx_a), 32'(vecs[i].idx));
            check($sformatf("vec%0d valid", i), 32'(val_a), 32'(vecs[i].valid));
            check_inst(1, "vecB");
        end

        // Reset in the middle of a grant acts without a clock edge.
        #3 rst = 1'b1;
        #1;
        check("midrst gnt_a", 32'(gnt_a), 32'h0);
        check("midrst idx_a", 32'(idx_a), 32'h0);
        check("midrst valid_a", 32'(val_a), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(4'b1110, 4'b0000);
        check("postrst gnt_a", 32'(gnt_a), 32'h2);
        check("postrst idx_a", 32'(idx_a), 32'h1);

        // Unlimited hold on instance B.
        for (int i = 0; i < 10; i++) begin
            step(4'b0000, 4'b1001);
            check($sformatf("unlim%0d gnt_b", i), 32'(gnt_b), 32'h1);
        end
        step(4'b0000, 4'b1000);
        check("unlim drop gnt_b", 32'(gnt_b), 32'h8);
        check("unlim drop idx_b", 32'(idx_b), 32'h3);

        // Randomized traffic; patterns persist a few cycles so holds, limits
        // and handovers all get exercised.
        ra = 4'b0000;
        rb = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) ra = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) rb = 4'($urandom_range(0, 15));
            step(ra, rb);
            check_inst(0, $sformatf("rnd%0d", i));
            check_inst(1, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_hold.md
# rr_arbiter_hold

Parametrised round-robin arbiter with registered one-hot grant, grant hold (lock) and a burst limit that forces rotation when other requesters are waiting. It generalises the team's 3-requester synchronous round-robin arbiter to N requesters. It sits in front of shared resources, such as a memory port or bus master, where an owner keeps access for a multi-cycle transfer.

## Interface
- N, default 4: number of requesters; legal range N >= 2.
- MAX_HOLD, default 8: maximum consecutive grant cycles while another requester waits; 0 means unlimited hold.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  N  request vector; bit i is requester i.
- gnt  out  N  registered grant, one-hot or zero.
- gnt_idx  out  $clog2(N)  binary index of the granted requester; 0 when no grant.
- valid  out  1  high exactly when gnt != 0, in the same cycle.

## Operation
- Two-state FSM:
  - IDLE: no owner.
  - GRANT: owner = gnt_idx.
- Internal registers:
  - last: index of the most recent owner. Reset value N-1, so requester 0 has top priority after reset.
  - hold_cnt: width $clog2(MAX_HOLD+1). Counts cycles the current owner has held gnt; value is 1 in the first grant cycle.
- Pick function: the first set bit of req, searching upward from (last+1) mod N with wrap-around.
- IDLE:
  - If req != 0: grant the picked requester, go to GRANT, hold_cnt=1, last=picked.
  - Else stay in IDLE with gnt=0.
- GRANT, with o = owner:
  - req[o]=1 and (MAX_HOLD=0 or hold_cnt<MAX_HOLD): keep the grant; hold_cnt++ (saturates at MAX_HOLD).
  - req[o]=1, hold_cnt==MAX_HOLD, no other req bit set: keep the grant; hold_cnt stays at MAX_HOLD.
  - req[o]=1, hold_cnt==MAX_HOLD, another req bit set: hand over to the pick starting at o+1; the pick must not be o. Set hold_cnt=1, last=new owner.
  - req[o]=0 and another req bit set: hand over to the pick at the same edge, with no idle gap. Set hold_cnt=1.
  - req[o]=0 and req==0: go to IDLE; gnt=0, hold_cnt=0.
- Requests are level-sensitive and not latched. A request dropped before being granted is forgotten.
- gnt is never multi-hot. gnt_idx and valid are always consistent with gnt.

## Timing
- Reset values (asynchronous assert): gnt=0, gnt_idx=0, valid=0, state=IDLE, hold_cnt=0, last=N-1.
- Reset mid-grant clears gnt on the reset edge itself. After reset deasserts, the first grant appears after the first clk edge that samples req.
- Latency: req sampled at edge k gives gnt visible after edge k, i.e. one cycle from request assertion to grant.
- Release: the owner dropping req at edge k makes gnt change at edge k; a new owner or zero is visible in the following cycle.
- Back-to-back handover costs zero idle cycles.
- Fairness bound: a continuously requesting requester is granted within (N-1)*MAX_HOLD cycles (MAX_HOLD>0) of its request being sampled.
- Asynchronous reset deassertion is synchronised externally; the block assumes rst release is clean relative to clk.

## Structure
- Shared package arb_pkg:
  - typedef for the FSM state enum (IDLE, GRANT).
  - Localparam helper for index width, $clog2(N) with a minimum of 1.
- Sub-module rr_pick: purely combinational rotating-priority picker.
  - Inputs: req[N], start index.
  - Outputs: pick_idx, pick_valid.
  - Implemented with a double-width request vector, or mask-and-fallback, for N-generic wrap.
- Top level holds the FSM, the last/hold_cnt registers and the output registers.

## Test plan
- N=4, MAX_HOLD=4, reset then req=4'b1111 held: gnt=0001 for 4 cycles, then 0010 x4, 0100 x4, 1000 x4, wrap to 0001; valid constantly 1.
- req=4'b0100 held for 20 cycles, with no other requesters: gnt=0100 for all 20 cycles; hold_cnt saturates at 4 and there is no spurious rotation.
- Owner 1 drops req while req[3] is high: at the same edge gnt goes 0010 -> 1000 with no zero cycle; gnt_idx=3.
- All requests drop: gnt=0, valid=0 the next cycle. Then req=4'b0011 with last=3: gnt=0001.
- Assert rst mid-grant (gnt=0100): gnt, gnt_idx and valid go to 0 immediately without a clk edge. After release with req=4'b1110: gnt=0010.
- MAX_HOLD=0, req=4'b1001 held: gnt=0001 forever. Drop req[0]: gnt=1000 next cycle.
